quantum_timer: RTL and testbench

- Preemption scheduler for the multitasking processor; sits beside unit_control.
- Counts retired instructions (done_inst pulses) against a programmable quantum and raises a preemption request when the quantum is exhausted.
- Releases the core from Halt through wake_up.
- Supplies the values read by GETTIME (free-running cycle count) and GETQUANTUM (remaining quantum).

---
 rtl/quantum_timer.sv | 161 ++++++++++++++++
 tb/tb_quantum_timer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quantum_timer.sv
`default_nettype none
// ============================================================================
// Module      : quantum_timer
// Description : Preemption scheduler beside unit_control. Counts retired
//               instructions against a programmable quantum, raises a
//               preemption request when the quantum runs out, wakes the core
//               from Halt, and supplies GETTIME / GETQUANTUM values.
// Optional    : QUANTUM_CYCLE_MODE_EN - when defined, the quantum is charged
//               one unit per clock in RUN (done_inst ignored) and is frozen
//               while the core is halted.
// Ports       :
//   clk           in   system clock (posedge)
//   rst_n         in   asynchronous active-low reset
//   sched_en      in   level, enables quantum counting / preemption
//   done_inst     in   pulse per retired instruction
//   quantum_load  in   pulse, captures quantum_in
//   quantum_in    in   [WIDTH] new quantum (0 selects DEFAULT_QUANTUM)
//   irq_ack       in   pulse, OS accepted the preemption
//   halted        in   level, core is in Halt
//   ext_event     in   pulse, external wake source
//   time_count    out  [WIDTH] free-running cycle count (GETTIME)
//   quantum_left  out  [WIDTH] remaining quantum (GETQUANTUM)
//   preempt_req   out  level preemption request
//   wake_up       out  level wake request to Halt
// Revision    : 1.0 - initial release
// ============================================================================
module quantum_timer #(
  parameter int          WIDTH           = 32,
  parameter int unsigned DEFAULT_QUANTUM = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sched_en,
  input  logic             done_inst,
  input  logic             quantum_load,
  input  logic [WIDTH-1:0] quantum_in,
  input  logic             irq_ack,
  input  logic             halted,
  input  logic             ext_event,
  output logic [WIDTH-1:0] time_count,
  output logic [WIDTH-1:0] quantum_left,
  output logic             preempt_req,
  output logic             wake_up
);

  localparam logic [WIDTH-1:0] DEF_Q = WIDTH'(DEFAULT_QUANTUM);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] quantum_reg, quantum_reg_nx;
  logic [WIDTH-1:0] quantum_left_nx;
  logic             preempt_nx;
  logic             wake_nx;
  logic             expire_now;
  logic             halted_d;
  logic             charge;

  // What consumes one unit of quantum in RUN.
`ifdef QUANTUM_CYCLE_MODE_EN
  assign charge = ~halted;
`else
  assign charge = done_inst;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // A load takes effect in the same cycle, so a coincident reload sees it.
    quantum_reg_nx = quantum_reg;
    if (quantum_load) begin
      quantum_reg_nx = (quantum_in == '0) ? DEF_Q : quantum_in;
    end

    state_nx        = state;
    quantum_left_nx = quantum_left;
    preempt_nx      = preempt_req;
    expire_now      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        quantum_left_nx = quantum_reg_nx;
        if (sched_en) begin
          state_nx = ST_RUN;
        end
      end

      ST_RUN: begin
        // Disabling the scheduler outranks a coincident charge.
        if (!sched_en) begin
          state_nx        = ST_IDLE;
          quantum_left_nx = quantum_reg_nx;
        end else if (charge) begin
          if (quantum_left > ONE) begin
            quantum_left_nx = quantum_left - ONE;
          end else begin
            // Covers ==1 and, defensively, ==0 so the count cannot wrap.
            quantum_left_nx = '0;
            preempt_nx      = 1'b1;
            state_nx        = ST_EXPIRED;
            expire_now      = 1'b1;
          end
        end
      end

      ST_EXPIRED: begin
        // Request is only released by an ack; sched_en=0 alone keeps it.
        if (irq_ack) begin
          preempt_nx      = 1'b0;
          quantum_left_nx = quantum_reg_nx;
          state_nx        = sched_en ? ST_RUN : ST_IDLE;
        end
      end

      default: begin
        state_nx        = ST_IDLE;
        quantum_left_nx = quantum_reg_nx;
        preempt_nx      = 1'b0;
      end
    endcase

    // Wake is sticky while halted and unconditionally dropped once awake.
    wake_nx = wake_up;
    if (!halted) begin
      wake_nx = 1'b0;
    end else if (ext_event || expire_now || (!halted_d && preempt_req)) begin
      wake_nx = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      time_count   <= '0;
      quantum_reg  <= DEF_Q;
      quantum_left <= DEF_Q;
      preempt_req  <= 1'b0;
      wake_up      <= 1'b0;
      halted_d     <= 1'b0;
    end else begin
      state        <= state_nx;
      time_count   <= time_count + ONE;
      quantum_reg  <= quantum_reg_nx;
      quantum_left <= quantum_left_nx;
      preempt_req  <= preempt_nx;
      wake_up      <= wake_nx;
      halted_d     <= halted;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quantum_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_quantum_timer
// Description : Self-checking bench for quantum_timer (WIDTH=8). A behavioural
//               model tracks every output each cycle; a vector table and
//               directed sequences cover expiry, ack, reload and wake cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quantum_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sched_en, done_inst, quantum_load, irq_ack, halted, ext_event;
  logic [W-1:0] quantum_in;
  logic [W-1:0] time_count, quantum_left;
  logic         preempt_req, wake_up;

  int n_cmp = 0;
  int n_bad = 0;

  quantum_timer #(.WIDTH(W), .DEFAULT_QUANTUM(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sched_en     (sched_en),
    .done_inst    (done_inst),
    .quantum_load (quantum_load),
    .quantum_in   (quantum_in),
    .irq_ack      (irq_ack),
    .halted       (halted),
    .ext_event    (ext_event),
    .time_count   (time_count),
    .quantum_left (quantum_left),
    .preempt_req  (preempt_req),
    .wake_up      (wake_up)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // phase: 0 idle, 1 counting, 2 waiting for ack
  int m_time, m_qreg, m_left, m_phase;
  bit m_pre, m_wake, m_prev_h;

  task automatic model_reset();
    m_time = 0; m_qreg = 100; m_left = 100; m_phase = 0;
    m_pre = 0; m_wake = 0; m_prev_h = 0;
  endtask

  task automatic model_step(input bit se, d, ld, input int qi, input bit ak, h, ex);
    bit expiring   = 0;
    bit pre_before = m_pre;
    if (ld) m_qreg = (qi == 0) ? 100 : qi;
    m_time = (m_time + 1) % 256;
    if (m_phase == 0) begin
      m_left = m_qreg;
      if (se) m_phase = 1;
    end else if (m_phase == 1) begin
      if (!se) begin
        m_phase = 0; m_left = m_qreg;
      end else if (d) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_pre = 1; m_phase = 2; expiring = 1;
        end
      end
    end else if (ak) begin
      m_pre = 0; m_left = m_qreg; m_phase = se ? 1 : 0;
    end
    if (!h) m_wake = 0;
    else if (ex || expiring || (!m_prev_h && pre_before)) m_wake = 1;
    m_prev_h = h;
  endtask

  // ---------------------------------------------------------------- checks
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("time_count",   int'(time_count),   m_time);
    chk("quantum_left", int'(quantum_left), m_left);
    chk("preempt_req",  int'(preempt_req),  int'(m_pre));
    chk("wake_up",      int'(wake_up),      int'(m_wake));
  endtask

  // One clock: drive inputs, step the model at the edge, compare 1ns later.
  task automatic cycle(input bit se, d, ld, input int qi, input bit ak, h, ex);
    sched_en = se; done_inst = d; quantum_load = ld; quantum_in = W'(qi);
    irq_ack = ak; halted = h; ext_event = ex;
    @(posedge clk);
    model_step(se, d, ld, qi, ak, h, ex);
    #1;
    chk_model();
  endtask

  // Async reset: outputs must clear without any clock edge.
  task automatic do_reset();
    sched_en = 0; done_inst = 0; quantum_load = 0; quantum_in = '0;
    irq_ack = 0; halted = 0; ext_event = 0;
    rst_n = 1'b0;
    #1;
    chk("rst time_count",   int'(time_count),   0);
    chk("rst quantum_left", int'(quantum_left), 100);
    chk("rst preempt_req",  int'(preempt_req),  0);
    chk("rst wake_up",      int'(wake_up),      0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic dones(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    bit se, d, ld; int qi; bit ak, h, ex;
    int e_left; bit e_pre, e_wake;
  } vec_t;

  vec_t tbl[17];

  initial begin
    bit found;
    rst_n = 1'b1;
    sched_en = 0; done_inst = 0; quantum_load = 0; quantum_in = '0;
    irq_ack = 0; halted = 0; ext_event = 0;
    #2;

    //          se d ld qi ak h ex  left pre wake
    tbl[0]  = '{0, 0, 1, 0, 0, 0, 0, 100, 0, 0};  // load 0 -> default
    tbl[1]  = '{0, 0, 1, 3, 0, 0, 0,   3, 0, 0};  // idle reload sees new value
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0,   3, 0, 0};  // idle -> run
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 0,   2, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 0,   1, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 0, 1, 0,   0, 1, 1};  // expiry while halted wakes
    tbl[6]  = '{1, 1, 0, 0, 0, 1, 0,   0, 1, 1};  // done ignored in expired
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 0,   0, 1, 0};  // wake drops after halt falls
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 0};  // sched_en=0 keeps request
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 0,   0, 1, 1};  // halt rises with request
    tbl[10] = '{1, 1, 0, 0, 1, 1, 0,   3, 0, 1};  // ack beats done
    tbl[11] = '{1, 1, 0, 0, 0, 0, 0,   2, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 1,   2, 0, 0};  // ext_event not halted
    tbl[13] = '{1, 0, 0, 0, 1, 0, 0,   2, 0, 0};  // ack outside expired
    tbl[14] = '{0, 1, 0, 0, 0, 0, 0,   3, 0, 0};  // disable beats done
    tbl[15] = '{0, 0, 0, 0, 0, 1, 1,   3, 0, 1};  // ext_event while halted
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0,   3, 0, 0};

    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].se, tbl[i].d, tbl[i].ld, tbl[i].qi, tbl[i].ak, tbl[i].h, tbl[i].ex);
      chk($sformatf("tbl%0d left", i), int'(quantum_left), tbl[i].e_left);
      chk($sformatf("tbl%0d pre",  i), int'(preempt_req),  int'(tbl[i].e_pre));
      chk($sformatf("tbl%0d wake", i), int'(wake_up),      int'(tbl[i].e_wake));
    end

    // Default quantum: 100 pulses, request one cycle after the last.
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 100; i++) begin
      cycle(1, 1, 0, 0, 0, 0, 0);
      if (i == 99) begin
        chk("q100 left@99", int'(quantum_left), 1);
        chk("q100 pre@99",  int'(preempt_req),  0);
      end
    end
    chk("q100 pre", int'(preempt_req), 1);
    chk("q100 left", int'(quantum_left), 0);

    // Load during RUN applies only at the next reload.
    do_reset();
    cycle(0, 0, 1, 0, 0, 0, 0);
    chk("load0 left", int'(quantum_left), 100);
    cycle(1, 0, 0, 0, 0, 0, 0);
    dones(60);
    chk("run left40", int'(quantum_left), 40);
    cycle(1, 0, 1, 5, 0, 0, 0);
    chk("load5 keeps 40", int'(quantum_left), 40);
    dones(39);
    chk("left1", int'(quantum_left), 1);
    dones(1);
    chk("expired pre", int'(preempt_req), 1);
    cycle(1, 1, 0, 0, 1, 0, 0);
    chk("ack reload 5", int'(quantum_left), 5);
    chk("ack pre clr", int'(preempt_req), 0);
    dones(1);
    chk("back in run", int'(quantum_left), 4);

    // Disable in RUN with coincident done.
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    dones(97);
    chk("left3", int'(quantum_left), 3);
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("disable reload", int'(quantum_left), 100);
    chk("disable pre", int'(preempt_req), 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("idle ignores done", int'(quantum_left), 100);

    // Wake sequence.
    cycle(0, 0, 0, 0, 0, 1, 0);
    chk("halt no src", int'(wake_up), 0);
    cycle(0, 0, 0, 0, 0, 1, 1);
    chk("wake set", int'(wake_up), 1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    chk("wake held", int'(wake_up), 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("wake clr", int'(wake_up), 0);

    // Randomized traffic against the model.
    begin
      bit h = 0, se = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(9) == 0)  h  = ~h;
        if ($urandom_range(29) == 0) se = ~se;
        cycle(se, 1'($urandom_range(1)), ($urandom_range(19) == 0),
              int'($urandom_range(20)), ($urandom_range(7) == 0), h,
              ($urandom_range(9) == 0));
      end
    end

    // Time counter wrap.
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (time_count == 8'd255) found = 1;
      else cycle(0, 0, 0, 0, 0, 0, 0);
    end
    chk("reach 255", int'(found), 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("wrap to 0", int'(time_count), 0);

    // Async reset mid-RUN with quantum_left=37 and wake_up active.
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    dones(63);
    chk("left37", int'(quantum_left), 37);
    cycle(1, 0, 0, 0, 0, 1, 1);
    chk("wake before rst", int'(wake_up), 1);
    #3;
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
